// File: rtl/cmp_track_pkg.sv
// Shared types and defaults for the comparator/tracker block.
// Holds the tracker state encoding and the default operand and counter widths.
package cmp_track_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } track_state_t;

endpackage

// File: rtl/cmp_track_core.sv
// Combinational comparator: unsigned/signed less-than, equality, and the
// less-than result chosen by mode (1 = two's complement).
module cmp_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             mode,
    output logic             lt_u,
    output logic             lt_s,
    output logic             eq,
    output logic             lt
);

    assign lt_u = (x < y);
    assign lt_s = ($signed(x) < $signed(y));
    assign eq   = (x == y);
    assign lt   = mode ? lt_s : lt_u;

endmodule

// File: rtl/cmp_track.sv
// Two-stage compare pipeline with a running min/max/less-than tracker on A.
// S1 registers the sample; S2 registers the compare results and updates the tracker.
module cmp_track
    import cmp_track_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             track_signed,
    input  logic             clear,
    output logic             out_valid,
    output logic             ans1,
    output logic             ans2,
    output logic             eq,
    output logic [WIDTH-1:0] min_a,
    output logic [WIDTH-1:0] max_a,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             cnt_sat,
    output logic             have_data
);

    localparam int NUM_LANES = 3;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic             s1_signed_reg;

    logic             out_valid_reg;
    logic             ans1_reg;
    logic             ans2_reg;
    logic             eq_reg;

    track_state_t     state_reg, state_next;
    logic [WIDTH-1:0] min_reg, min_next;
    logic [WIDTH-1:0] max_reg, max_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Lane 0: a vs b. Lane 1: a vs current min. Lane 2: current max vs a.
    logic [WIDTH-1:0] lane_x    [NUM_LANES];
    logic [WIDTH-1:0] lane_y    [NUM_LANES];
    logic             lane_lt_u [NUM_LANES];
    logic             lane_lt_s [NUM_LANES];
    logic             lane_eq   [NUM_LANES];
    logic             lane_lt   [NUM_LANES];

    assign lane_x[0] = s1_a_reg;
    assign lane_y[0] = s1_b_reg;
    assign lane_x[1] = s1_a_reg;
    assign lane_y[1] = min_reg;
    assign lane_x[2] = max_reg;
    assign lane_y[2] = s1_a_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            cmp_core #(
                .WIDTH(WIDTH)
            ) u_core (
                .x    (lane_x[gi]),
                .y    (lane_y[gi]),
                .mode (s1_signed_reg),
                .lt_u (lane_lt_u[gi]),
                .lt_s (lane_lt_s[gi]),
                .eq   (lane_eq[gi]),
                .lt   (lane_lt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_signed_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            ans1_reg      <= 1'b0;
            ans2_reg      <= 1'b0;
            eq_reg        <= 1'b0;
        end else begin
            s1_valid_reg  <= in_valid;
            if (in_valid) begin
                s1_a_reg      <= a;
                s1_b_reg      <= b;
                s1_signed_reg <= track_signed;
            end
            // Results hold their last value between completed samples.
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                ans1_reg <= lane_lt_u[0];
                ans2_reg <= lane_lt_s[0];
                eq_reg   <= lane_eq[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= EMPTY;
            min_reg   <= '0;
            max_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            min_reg   <= min_next;
            max_reg   <= max_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        min_next   = min_reg;
        max_next   = max_reg;
        cnt_next   = cnt_reg;
        // clear wins over a sample completing on the same edge.
        if (clear) begin
            state_next = EMPTY;
            min_next   = '0;
            max_next   = '0;
            cnt_next   = '0;
        end else if (s1_valid_reg) begin
            case (state_reg)
                EMPTY: begin
                    min_next   = s1_a_reg;
                    max_next   = s1_a_reg;
                    cnt_next   = {{(CNT_W-1){1'b0}}, lane_lt[0]};
                    state_next = TRACK;
                end
                TRACK: begin
                    if (lane_lt[1]) begin
                        min_next = s1_a_reg;
                    end
                    if (lane_lt[2]) begin
                        max_next = s1_a_reg;
                    end
                    if (lane_lt[0] && !(&cnt_reg)) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign ans1      = ans1_reg;
    assign ans2      = ans2_reg;
    assign eq        = eq_reg;
    assign min_a     = min_reg;
    assign max_a     = max_reg;
    assign lt_cnt    = cnt_reg;
    assign cnt_sat   = &cnt_reg;
    assign have_data = (state_reg == TRACK);

endmodule

// File: tb/tb_cmp_track.sv
// Scoreboard bench for cmp_track: compare results are queued at drive time and
// popped when out_valid appears; tracker state is checked against fixed expectations.
module tb_cmp_track;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          track_signed;
    logic          clear;
    logic          out_valid;
    logic          ans1;
    logic          ans2;
    logic          eq;
    logic [W-1:0]  min_a;
    logic [W-1:0]  max_a;
    logic [CW-1:0] lt_cnt;
    logic          cnt_sat;
    logic          have_data;

    typedef struct {
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        logic         a1;
        logic         a2;
        logic         e;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    cmp_track #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .a            (a),
        .b            (b),
        .track_signed (track_signed),
        .clear        (clear),
        .out_valid    (out_valid),
        .ans1         (ans1),
        .ans2         (ans2),
        .eq           (eq),
        .min_a        (min_a),
        .max_a        (max_a),
        .lt_cnt       (lt_cnt),
        .cnt_sat      (cnt_sat),
        .have_data    (have_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one sample for one edge; signed order is found by flipping the sign bit.
    task automatic sample(input logic [W-1:0] sa, input logic [W-1:0] sb_, input logic sm,
                          input logic sclr);
        exp_t e;
        in_valid     = 1'b1;
        a            = sa;
        b            = sb_;
        track_signed = sm;
        clear        = sclr;
        e.xa  = sa;
        e.xb  = sb_;
        e.a1  = (sa < sb_);
        e.a2  = ((sa ^ 4'h8) < (sb_ ^ 4'h8));
        e.e   = (sa == sb_);
        e.due = cyc + 2;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_ov", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("ov_cycle", cyc, e.due);
                    check("ans1", {31'd0, ans1}, {31'd0, e.a1});
                    check("ans2", {31'd0, ans2}, {31'd0, e.a2});
                    check("eq", {31'd0, eq}, {31'd0, e.e});
                    $display("txn cyc=%0d a=%h b=%h ans1=%b ans2=%b eq=%b min=%h max=%h cnt=%0d",
                             cyc, e.xa, e.xb, ans1, ans2, eq, min_a, max_a, lt_cnt);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                check("missing_ov", 32'd0, 32'd1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        reset        = 1'b0;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        track_signed = 1'b0;
        clear        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_ans1", ans1, 0);
        check("rst_min", min_a, 0);
        check("rst_max", max_a, 0);
        check("rst_cnt", lt_cnt, 0);
        check("rst_have", have_data, 0);
        reset = 1'b1;
        idle(1);

        // Single sample, unsigned less but signed not
        sample(4'd4, 4'hF, 1'b0, 1'b0);
        idle(3);
        check("t1_have", have_data, 1);
        check("t1_min", min_a, 4);
        check("t1_max", max_a, 4);
        check("t1_cnt", lt_cnt, 1);
        check("t1_ans1_hold", ans1, 1);
        do_clear();
        check("clr_have", have_data, 0);
        check("clr_cnt", lt_cnt, 0);
        check("clr_min", min_a, 0);

        // Back-to-back unsigned
        sample(4'd4, 4'd7, 1'b0, 1'b0);
        sample(4'd4, 4'd15, 1'b0, 1'b0);
        sample(4'd5, 4'd5, 1'b0, 1'b0);
        idle(3);
        check("t2_cnt", lt_cnt, 2);
        check("t2_min", min_a, 4);
        check("t2_max", max_a, 5);
        do_clear();

        // Signed tracking
        sample(4'd7, 4'd0, 1'b1, 1'b0);
        sample(4'h8, 4'd0, 1'b1, 1'b0);
        sample(4'd3, 4'd0, 1'b1, 1'b0);
        idle(3);
        check("t3_min", min_a, 4'h8);
        check("t3_max", max_a, 7);
        check("t3_cnt", lt_cnt, 1);
        check("t3_have", have_data, 1);
        do_clear();

        // Counter saturation
        for (int i = 0; i < 5; i++) begin
            sample(4'd1, 4'd2, 1'b0, 1'b0);
            if (i >= 1) begin
                check("t4_cnt", lt_cnt, (i > 3) ? 3 : i);
                check("t4_sat", cnt_sat, (i >= 3) ? 1 : 0);
            end
        end
        idle(1);
        check("t4_cnt_end", lt_cnt, 3);
        check("t4_sat_end", cnt_sat, 1);
        idle(2);
        do_clear();
        check("t4_sat_clr", cnt_sat, 0);

        // clear coincident with a completing sample, then with an accepted one
        sample(4'd6, 4'd1, 1'b0, 1'b0);
        idle(2);
        sample(4'd4, 4'd7, 1'b0, 1'b0);
        do_clear();
        check("t5_ov", out_valid, 1);
        check("t5_ans1", ans1, 1);
        check("t5_have", have_data, 0);
        check("t5_cnt", lt_cnt, 0);
        sample(4'd6, 4'd1, 1'b0, 1'b0);
        idle(2);
        check("t5_pre_min", min_a, 6);
        sample(4'd9, 4'd3, 1'b0, 1'b1);
        idle(1);
        check("t5_min", min_a, 9);
        check("t5_max", max_a, 9);
        check("t5_have2", have_data, 1);
        check("t5_cnt2", lt_cnt, 0);
        idle(2);

        // Asynchronous reset with samples in flight
        sample(4'd1, 4'd2, 1'b0, 1'b0);
        sample(4'd3, 4'd4, 1'b0, 1'b0);
        in_valid = 1'b1;
        a        = 4'd5;
        b        = 4'd6;
        #2;
        reset = 1'b0;
        sbq.delete();
        #1;
        check("t6_ov", out_valid, 0);
        check("t6_ans1", ans1, 0);
        check("t6_min", min_a, 0);
        check("t6_max", max_a, 0);
        check("t6_cnt", lt_cnt, 0);
        check("t6_have", have_data, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("t6_no_ov", out_valid, 0);
        end

        check("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_track.md
CMP_TRACK -- requirements
Module: cmp_track

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal range 2..32).
REQ-002 Parameter CNT_W, default 8, width of the less-than event counter (legal range 2..16).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 in_valid  input  1  high = a, b and track_signed form a sample accepted this edge.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 track_signed  input  1  1 = two's-complement tracking; 0 = unsigned tracking.
REQ-009 clear  input  1  synchronous, pulse: empties tracker state.
REQ-010 out_valid  output  1  high for one cycle per completed sample.
REQ-011 ans1  output  1  unsigned a < b for the completed sample.
REQ-012 ans2  output  1  signed a < b for the completed sample.
REQ-013 eq  output  1  a == b for the completed sample.
REQ-014 min_a  output  WIDTH  running minimum of A in the selected mode.
REQ-015 max_a  output  WIDTH  running maximum of A in the selected mode.
REQ-016 lt_cnt  output  CNT_W  count of samples where the mode-selected a < b holds.
REQ-017 cnt_sat  output  1  high while lt_cnt equals all-ones.
REQ-018 have_data  output  1  high when the tracker holds at least one sample.

Function
REQ-019 The block SHALL be a two-stage pipeline: S1 registers in_valid, a, b and track_signed; S2 computes results and updates the tracker.
REQ-020 A sample accepted at edge N SHALL show out_valid=1 with its ans1, ans2 and eq after edge N+1, giving a fixed latency of 2.
REQ-021 A new sample SHALL be accepted on every edge with no stalls; back-to-back samples SHALL give back-to-back out_valid.
REQ-022 ans1, ans2 and eq SHALL hold their last value while out_valid=0.
REQ-023 The tracker FSM SHALL have two states: EMPTY (have_data=0) and TRACK (have_data=1).
REQ-024 In EMPTY, a completing sample SHALL load min_a=max_a=a, load lt_cnt with its lt bit (0 or 1), and move the FSM to TRACK.
REQ-025 In TRACK, a completing sample SHALL update min_a/max_a using the comparison mode of that sample, and SHALL increment lt_cnt if its mode-selected a < b.
REQ-026 lt_cnt SHALL saturate at 2^CNT_W-1 and never wrap; cnt_sat SHALL be derived combinationally from lt_cnt.
REQ-027 clear at edge M SHALL move the FSM to EMPTY and zero min_a, max_a and lt_cnt; clear does not flush S1.
REQ-028 If clear coincides with a completing S2 sample, the sample's ans1/ans2/eq/out_valid SHALL still be emitted, the tracker SHALL discard the sample, and clear wins.
REQ-029 A sample in S1 when clear is asserted SHALL complete normally on the next edge and enter the now-EMPTY tracker.
REQ-030 Equal values SHALL not change min_a/max_a and SHALL not count as lt.

Reset
REQ-031 While reset=0, all registers SHALL clear immediately, independent of clk.
REQ-032 Reset values SHALL be: out_valid=0, ans1=0, ans2=0, eq=0, min_a=0, max_a=0, lt_cnt=0, FSM=EMPTY, and S1 valid=0.
REQ-033 Samples in flight when reset asserts SHALL be lost, with no out_valid after release.
REQ-034 The first sample accepted after reset release SHALL behave as in REQ-024.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (EMPTY/TRACK) and the default WIDTH/CNT_W constants.
REQ-036 One sub-module, cmp_core, SHALL be instantiated: a combinational unit that takes x, y and mode, and outputs lt_u, lt_s, eq and the mode-selected lt; it is used for both the a/b comparison and the min/max comparison.

Verification
REQ-037 WIDTH=4, reset released, then in_valid pulses with a=4, b=4'hF -> two cycles later out_valid=1, ans1=1, ans2=0, eq=0.
REQ-038 Back-to-back samples (4,7), then (4,15), then (5,5) with track_signed=0 -> ans1/ans2 = 1/1, then 1/0, then 0/0 with eq=1; lt_cnt=2; min_a=4; max_a=5.
REQ-039 track_signed=1 with a sequence 7, 4'h8, 3 (b=0) -> min_a=4'h8, max_a=7, lt_cnt=1 (the 4'h8 sample), have_data=1.
REQ-040 CNT_W=2 with five consecutive lt samples -> lt_cnt counts 1,2,3,3,3 and cnt_sat rises when lt_cnt reaches 3.
REQ-041 clear coincident with a completing sample (4,7) -> out_valid=1 and ans1=1, while next cycle have_data=0 and lt_cnt=0; a following sample a=9 gives min_a=max_a=9.
REQ-042 reset asserted mid-edge with two samples in flight -> all outputs 0 immediately and no out_valid after release.
